q31_to_fp32_pipe: RTL and testbench



---
 rtl/q31_fp32_pkg.sv | 15 +
 rtl/lzd_32bit.sv | 45 ++++
 rtl/q31_to_fp32_pipe.sv | 116 +++++++++++
 tb/tb_q31_to_fp32_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q31_fp32_pkg.sv
// Shared constants for the Q1.31 to binary32 converter.
`timescale 1ns/1ps
package q31_fp32_pkg;
    localparam int Q_W     = 32;
    localparam int MANT_W  = 23;
    localparam int EXP_W   = 8;
    localparam int FP_BIAS = 127;
    localparam int LZD_W   = 6;

    // Mantissa rounding selection
    typedef enum logic {
        RND_TRUNC        = 1'b0,
        RND_NEAREST_EVEN = 1'b1
    } round_sel_e;
endpackage

// File: rtl/lzd_32bit.sv
// Leading-zero detectors: a 16-bit priority encoder and a 32-bit detector
// built from two of them. Both are purely combinational.
`timescale 1ns/1ps
module lzd_16bit (
    input  logic [15:0] i_data,
    output logic [4:0]  o_lzd,
    output logic        o_zero
);
    // Highest set bit wins; an all-zero input reports 16
    always_comb begin
        o_lzd = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (i_data[i]) o_lzd = 5'(15 - i);
        end
    end

    assign o_zero = ~|i_data;
endmodule

module lzd_32bit import q31_fp32_pkg::*; (
    input  logic [Q_W-1:0]   i_data,
    output logic [LZD_W-1:0] o_lzd,
    output logic             o_all_zero
);
    logic [4:0] w_hi_lzd;
    logic [4:0] w_lo_lzd;
    logic       w_hi_zero;
    logic       w_lo_zero;

    lzd_16bit u_hi (
        .i_data (i_data[31:16]),
        .o_lzd  (w_hi_lzd),
        .o_zero (w_hi_zero)
    );

    lzd_16bit u_lo (
        .i_data (i_data[15:0]),
        .o_lzd  (w_lo_lzd),
        .o_zero (w_lo_zero)
    );

    // Low half reports 16 when empty, so an all-zero word yields 32
    assign o_lzd      = w_hi_zero ? (6'd16 + {1'b0, w_lo_lzd}) : {1'b0, w_hi_lzd};
    assign o_all_zero = w_hi_zero & w_lo_zero;
endmodule

// File: rtl/q31_to_fp32_pipe.sv
// Three-stage Q1.31 to IEEE-754 binary32 converter with valid/ready on both
// sides: S1 sign/magnitude, S2 normalise, S3 round and pack.
`timescale 1ns/1ps
module q31_to_fp32_pipe import q31_fp32_pkg::*; #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] out_data,
    output logic           busy
);
    localparam round_sel_e ROUND_SEL = ROUND_EN ? RND_NEAREST_EVEN : RND_TRUNC;

    logic             r_v1, r_v2, r_v3;
    logic             r_s1, r_s2, r_z2;
    logic [Q_W-1:0]   r_m1;
    logic [30:0]      r_n2;
    logic [LZD_W-1:0] r_lzd2;
    logic [Q_W-1:0]   r_out;

    logic             w_load1, w_load2, w_load3;
    logic             w_adv1, w_adv2;
    logic [Q_W-1:0]   w_mag;
    logic [LZD_W-1:0] w_lzd;
    logic             w_zero;
    logic [30:0]      w_norm;
    logic [MANT_W-1:0] w_mant_t;
    logic             w_guard, w_sticky, w_inc;
    logic [MANT_W:0]  w_mant_sum;
    logic [EXP_W-1:0] w_exp;
    logic [Q_W-1:0]   w_packed;

    // Backpressure chain: a stage may load when empty or when its content moves on
    assign w_load3  = ~r_v3 | out_ready;
    assign w_adv2   = r_v2 & w_load3;
    assign w_load2  = ~r_v2 | w_adv2;
    assign w_adv1   = r_v1 & w_load2;
    assign w_load1  = ~r_v1 | w_adv1;
    assign in_ready = w_load1;

    // Two's-complement negate; -1.0 wraps to 0x80000000, the correct magnitude
    assign w_mag = in_data[Q_W-1] ? (~in_data + 32'd1) : in_data;

    lzd_32bit u_lzd (
        .i_data     (r_m1),
        .o_lzd      (w_lzd),
        .o_all_zero (w_zero)
    );

    // Bit 31 of the normalised value is the implicit one and is not kept
    assign w_norm = 31'(r_m1 << w_lzd);

    assign w_mant_t   = r_n2[30:8];
    assign w_guard    = r_n2[7];
    assign w_sticky   = |r_n2[6:0];
    assign w_inc      = (ROUND_SEL == RND_NEAREST_EVEN) & w_guard & (w_sticky | r_n2[8]);
    assign w_mant_sum = {1'b0, w_mant_t} + {{MANT_W{1'b0}}, w_inc};
    // A mantissa carry-out leaves the low bits at zero and bumps the exponent
    assign w_exp      = EXP_W'(FP_BIAS) - {2'b00, r_lzd2}
                      + {{(EXP_W-1){1'b0}}, w_mant_sum[MANT_W]};
    assign w_packed   = r_z2 ? '0 : {r_s2, w_exp, w_mant_sum[MANT_W-1:0]};

    // S1: capture sign and magnitude of the accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_s1 <= 1'b0;
            r_m1 <= '0;
        end else if (w_load1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_s1 <= in_data[Q_W-1];
                r_m1 <= w_mag;
            end
        end
    end

    // S2: normalise the magnitude using the leading-zero count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_s2   <= 1'b0;
            r_z2   <= 1'b0;
            r_n2   <= '0;
            r_lzd2 <= '0;
        end else if (w_load2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2   <= r_s1;
                r_z2   <= w_zero;
                r_n2   <= w_norm;
                r_lzd2 <= w_lzd;
            end
        end
    end

    // S3: hold the packed result; frozen while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3  <= 1'b0;
            r_out <= '0;
        end else if (w_load3) begin
            r_v3 <= r_v2;
            if (r_v2) r_out <= w_packed;
        end
    end

    assign out_valid = r_v3;
    assign out_data  = r_out;
    assign busy      = r_v1 | r_v2 | r_v3;
endmodule

// File: tb/tb_q31_to_fp32_pipe.sv
// Directed bench for q31_to_fp32_pipe: a rounding instance and a truncating
// instance run in lockstep on the same handshake signals.
`timescale 1ns/1ps
module tb_q31_to_fp32_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_data;
    logic        t_in_ready, t_out_valid, t_busy;
    logic [31:0] t_out_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] din;
        logic [31:0] e_rne;
        logic [31:0] e_trc;
    } vec_t;

    vec_t vq[$];
    bit   rdy_pat[$];

    q31_to_fp32_pipe #(.ROUND_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    q31_to_fp32_pipe #(.ROUND_EN(1'b0)) dut_t (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (t_in_ready),
        .in_data   (in_data),
        .out_valid (t_out_valid),
        .out_ready (out_ready),
        .out_data  (t_out_data),
        .busy      (t_busy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] d, input logic [31:0] r, input logic [31:0] t);
        vec_t v;
        v.din = d;
        v.e_rne = r;
        v.e_trc = t;
        return v;
    endfunction

    // Streams vq through both instances with out_ready following rdy_pat.
    // Entered and left at posedge+1.
    task automatic stream_run(input string name, input int budget, output int cycles);
        int ii = 0;
        int oi = 0;
        int cyc = 0;
        bit hold = 1'b0;
        logic [31:0] held = 32'h0;
        while (oi < vq.size() && cyc < budget) begin
            if (ii < vq.size()) begin
                in_valid = 1'b1;
                in_data  = vq[ii].din;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rdy_pat[cyc % rdy_pat.size()];
            @(negedge clk);
            if (hold) begin
                n_cmp++;
                if (out_data !== held) begin
                    n_err++;
                    $display("FAIL %s_hold cyc=%0d got %h want %h", name, cyc, out_data, held);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_data !== vq[oi].e_rne) begin
                    n_err++;
                    $display("FAIL %s_rne[%0d] in=%h got %h want %h", name, oi, vq[oi].din, out_data, vq[oi].e_rne);
                end
                n_cmp++;
                if (t_out_data !== vq[oi].e_trc) begin
                    n_err++;
                    $display("FAIL %s_trc[%0d] in=%h got %h want %h", name, oi, vq[oi].din, t_out_data, vq[oi].e_trc);
                end
                oi++;
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) ii++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles = cyc;
        n_cmp++;
        if (oi != vq.size()) begin
            n_err++;
            $display("FAIL %s_timeout got %0d outputs want %0d", name, oi, vq.size());
        end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_extra got valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({out_valid, busy, in_ready, out_data} !== {1'b0, 1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL reset_state got v=%b b=%b r=%b d=%h want 0 0 1 00000000", out_valid, busy, in_ready, out_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        in_valid  = 1'b1;
        in_data   = 32'h4000_0000;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lat_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_e1 got busy=%b valid=%b want 1 0", busy, out_valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lat_e2 got valid=%b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F00_0000) begin
            n_err++;
            $display("FAIL lat_e3 got valid=%b data=%h want 1 3f000000", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL lat_e4 got valid=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        vq.delete();
        vq.push_back(mk(32'h4000_0000, 32'h3F00_0000, 32'h3F00_0000));
        vq.push_back(mk(32'hC000_0000, 32'hBF00_0000, 32'hBF00_0000));
        vq.push_back(mk(32'h8000_0000, 32'hBF80_0000, 32'hBF80_0000));
        vq.push_back(mk(32'h0000_0000, 32'h0000_0000, 32'h0000_0000));
        rdy_pat = '{1'b1};
        stream_run("basic", 50, cyc);
        n_cmp++;
        if (cyc != 7) begin
            n_err++;
            $display("FAIL basic_cycles got %0d want 7", cyc);
        end
    endtask

    task automatic test_extremes();
        int cyc;
        vq.delete();
        vq.push_back(mk(32'h0000_0001, 32'h3000_0000, 32'h3000_0000));
        vq.push_back(mk(32'hFFFF_FFFF, 32'hB000_0000, 32'hB000_0000));
        vq.push_back(mk(32'h7FFF_FFFF, 32'h3F80_0000, 32'h3F7F_FFFF));
        vq.push_back(mk(32'h8000_0001, 32'hBF80_0000, 32'hBF7F_FFFF));
        vq.push_back(mk(32'h0001_0000, 32'h3800_0000, 32'h3800_0000));
        rdy_pat = '{1'b1};
        stream_run("extreme", 50, cyc);
    endtask

    task automatic test_rounding();
        int cyc;
        vq.delete();
        vq.push_back(mk(32'h0000_0180, 32'h3440_0000, 32'h3440_0000));
        vq.push_back(mk(32'h4000_0040, 32'h3F00_0000, 32'h3F00_0000));
        vq.push_back(mk(32'h4000_00C0, 32'h3F00_0002, 32'h3F00_0001));
        vq.push_back(mk(32'h4000_0180, 32'h3F00_0003, 32'h3F00_0003));
        vq.push_back(mk(32'h4000_0041, 32'h3F00_0001, 32'h3F00_0000));
        vq.push_back(mk(32'h4000_0080, 32'h3F00_0001, 32'h3F00_0001));
        rdy_pat = '{1'b1};
        stream_run("round", 50, cyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        vq.delete();
        vq.push_back(mk(32'h2000_0000, 32'h3E80_0000, 32'h3E80_0000));
        vq.push_back(mk(32'hE000_0000, 32'hBE80_0000, 32'hBE80_0000));
        vq.push_back(mk(32'h1000_0000, 32'h3E00_0000, 32'h3E00_0000));
        vq.push_back(mk(32'h6000_0000, 32'h3F40_0000, 32'h3F40_0000));
        vq.push_back(mk(32'hA000_0000, 32'hBF40_0000, 32'hBF40_0000));
        vq.push_back(mk(32'h0001_0000, 32'h3800_0000, 32'h3800_0000));
        vq.push_back(mk(32'h0000_0003, 32'h30C0_0000, 32'h30C0_0000));
        vq.push_back(mk(32'hFFFF_0000, 32'hB800_0000, 32'hB800_0000));
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        stream_run("bp", 200, cyc);
    endtask

    task automatic test_stall_fill();
        logic [31:0] din[5] = '{32'h2000_0000, 32'hE000_0000, 32'h1000_0000, 32'h6000_0000, 32'hA000_0000};
        logic [31:0] exp[5] = '{32'h3E80_0000, 32'hBE80_0000, 32'h3E00_0000, 32'h3F40_0000, 32'hBF40_0000};
        int ii = 0;
        int oi = 0;
        int cyc = 0;
        out_ready = 1'b0;
        repeat (6) begin
            in_valid = 1'b1;
            in_data  = din[ii];
            @(negedge clk);
            if (in_ready) ii++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (ii != 3 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_fill got accepted=%0d ready=%b busy=%b want 3 0 1", ii, in_ready, busy);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== exp[0]) begin
            n_err++;
            $display("FAIL stall_head got valid=%b data=%h want 1 %h", out_valid, out_data, exp[0]);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_full_ready got %b want 1", in_ready);
        end
        while (oi < 5 && cyc < 30) begin
            in_valid = (ii < 5);
            if (ii < 5) in_data = din[ii];
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_cmp++;
                if (out_data !== exp[oi]) begin
                    n_err++;
                    $display("FAIL stall_out[%0d] got %h want %h", oi, out_data, exp[oi]);
                end
                oi++;
            end
            if (in_valid && in_ready) ii++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (oi != 5 || ii != 5) begin
            n_err++;
            $display("FAIL stall_drain got out=%0d in=%0d want 5 5", oi, ii);
        end
    endtask

    task automatic test_reset_midstream();
        int cyc;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 32'h1000_0000 + 32'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, busy, in_ready, out_data, t_out_data} !== {1'b0, 1'b0, 1'b1, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL midrst got v=%b b=%b r=%b d=%h t=%h want 0 0 1 0 0", out_valid, busy, in_ready, out_data, t_out_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vq.delete();
        vq.push_back(mk(32'h6000_0000, 32'h3F40_0000, 32'h3F40_0000));
        rdy_pat = '{1'b1};
        stream_run("postrst", 30, cyc);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_extremes();
        test_rounding();
        test_backpressure();
        test_stall_fill();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
